// File: rtl/gray_pkg.sv
// Shared Gray-code definitions for the counter and its downstream converter.
// Reused by reference models that need the binary-to-Gray mapping.
package gray_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam int GRAY_WIDTH_MAX     = 16;

    // Gray encoding of a binary value, sized for the widest legal counter
    function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(
        input logic [GRAY_WIDTH_MAX-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and result bundle of the Gray counter.
// The master drives the count controls; the slave returns the registered codes.
interface gray_counter_if
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
);

    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] Grayout;
    logic [WIDTH-1:0] bin_out;
    logic             wrap;

    modport master (
        output en,
        output up_dn,
        output load,
        output load_bin,
        input  Grayout,
        input  bin_out,
        input  wrap
    );

    modport slave (
        input  en,
        input  up_dn,
        input  load,
        input  load_bin,
        output Grayout,
        output bin_out,
        output wrap
    );

endinterface

// File: rtl/binary_to_gray.sv
// Combinational WIDTH-bit binary to Gray encoder.
// Feeds the D input of the counter's Gray register.
module binary_to_gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered binary and Gray outputs and a wrap pulse.
// Define GRAY_CNT_SATURATE_EN to clamp at the limits instead of rolling over.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    gray_counter_if.slave  bus
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_d;

    logic [WIDTH-1:0] step_val;
    logic             at_limit;

    // Neighbouring value and whether the step crosses the code-space edge
    always_comb begin
        step_val = bin_q;
        at_limit = 1'b0;
        if (bus.up_dn) begin
            step_val = bin_q + WIDTH'(1);
            at_limit = &bin_q;
        end else begin
            step_val = bin_q - WIDTH'(1);
            at_limit = (bin_q == '0);
        end
    end

    // Priority mux: load beats count, count beats hold
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bin_d  = bus.load_bin;
            wrap_d = 1'b0;
        end else if (bus.en) begin
`ifdef GRAY_CNT_SATURATE_EN
            if (at_limit) begin
                bin_d  = bin_q;
                wrap_d = 1'b1;
            end else begin
                bin_d  = step_val;
                wrap_d = 1'b0;
            end
`else
            bin_d  = step_val;
            wrap_d = at_limit;
`endif
        end
    end

    binary_to_gray #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin  (bin_d),
        .gray (gray_d)
    );

    // Binary, Gray and wrap registers share one edge; reset wins
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.bin_out = bin_q;
    assign bus.Grayout = gray_q;
    assign bus.wrap    = wrap_q;

endmodule
